// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: registered ALU with valid/ready handshake plus iterative
// shift-add multiply and restoring divide into HI/LO registers.
// Optional feature macro: ALU_OVERFLOW_EN adds a registered signed-overflow flag.
module alu_muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               inValid,
  output logic               inReady,
  input  logic [3:0]         aluCtrl,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               outValid,
  input  logic               outReady,
  output logic [WIDTH-1:0]   result,
  output logic               busy
`ifdef ALU_OVERFLOW_EN
  ,
  output logic               overflow
`endif
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_SRA, OP_SLT,
    OP_SLTU, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_NOR
  } op_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div_zero_q, div_zero_d;
  logic               is_div_q, is_div_d;
  logic               out_valid_q, out_valid_d;

  op_e                op;
  logic               accept;
  logic               signed_op;
  logic               is_div_op;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op        = op_e'(aluCtrl);
  assign inReady   = (state_q == IDLE) && (!out_valid_q || outReady);
  assign accept    = inValid && inReady;
  assign busy      = (state_q == MUL) || (state_q == DIV);
  assign outValid  = out_valid_q;
  assign result    = result_q;

  // Signed ops iterate on magnitudes; sign is restored when the op completes
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign sign_a    = signed_op && input1[WIDTH-1];
  assign sign_b    = signed_op && input2[WIDTH-1];
  assign abs_a     = sign_a ? -input1 : input1;
  assign abs_b     = sign_b ? -input2 : input2;

  // One multiply step: add multiplicand when the low product bit is set, then shift right
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  // One restoring-divide step: shift next dividend bit into the remainder and trial-subtract
  assign rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, opnd_q};
  // Final sign fix-up; a zero divisor forces an all-ones quotient, and the
  // remainder then holds |input1| re-signed, which equals input1
  assign prod_fix  = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign quo_fix   = div_zero_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
  assign rem_fix   = rem_neg_q ? -acc_hi_q : acc_hi_q;

  // Single-cycle ALU function
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = input1 + input2;
      OP_SUB:  alu_res = input1 - input2;
      OP_AND:  alu_res = input1 & input2;
      OP_OR:   alu_res = input1 | input2;
      OP_SLL:  alu_res = input2 << shamt;
      OP_SRL:  alu_res = input2 >> shamt;
      OP_SRA:  alu_res = $signed(input2) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_NOR:  alu_res = ~(input1 | input2);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic alu_ovf;
  logic ovf_q, ovf_d;

  assign overflow = ovf_q;

  // Signed overflow detection for ADD/SUB
  always_comb begin
    alu_ovf = 1'b0;
    if (op == OP_ADD)
      alu_ovf = (input1[WIDTH-1] == input2[WIDTH-1]) && (alu_res[WIDTH-1] != input1[WIDTH-1]);
    else if (op == OP_SUB)
      alu_ovf = (input1[WIDTH-1] != input2[WIDTH-1]) && (alu_res[WIDTH-1] != input1[WIDTH-1]);
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    opnd_d      = opnd_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    rem_neg_d   = rem_neg_q;
    div_zero_d  = div_zero_q;
    is_div_d    = is_div_q;
    out_valid_d = out_valid_q;
`ifdef ALU_OVERFLOW_EN
    ovf_d       = ovf_q;
`endif

    if (out_valid_q && outReady)
      out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
            state_d    = is_div_op ? DIV : MUL;
            cnt_d      = '0;
            acc_hi_d   = '0;
            acc_lo_d   = is_div_op ? abs_a : abs_b;
            opnd_d     = is_div_op ? abs_b : abs_a;
            neg_d      = sign_a ^ sign_b;
            rem_neg_d  = sign_a;
            div_zero_d = (input2 == '0);
            is_div_d   = is_div_op;
          end else begin
            result_d    = alu_res;
            out_valid_d = 1'b1;
`ifdef ALU_OVERFLOW_EN
            ovf_d       = alu_ovf;
`endif
          end
        end
      end
      MUL: begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHAMT_W'(WIDTH-1))
          state_d = DONE;
      end
      DIV: begin
        if (!rem_diff[WIDTH]) begin
          acc_hi_d = rem_diff[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = rem_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHAMT_W'(WIDTH-1))
          state_d = DONE;
      end
      DONE: begin
        if (is_div_q) begin
          hi_d     = rem_fix;
          lo_d     = quo_fix;
          result_d = quo_fix;
        end else begin
          hi_d     = prod_fix[2*WIDTH-1:WIDTH];
          lo_d     = prod_fix[WIDTH-1:0];
          result_d = prod_fix[WIDTH-1:0];
        end
        out_valid_d = 1'b1;
`ifdef ALU_OVERFLOW_EN
        ovf_d       = 1'b0;
`endif
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opnd_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      is_div_q    <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      opnd_q      <= opnd_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      rem_neg_q   <= rem_neg_d;
      div_zero_q  <= div_zero_d;
      is_div_q    <= is_div_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Bench for alu_muldiv_unit (WIDTH=32): randomized ops checked against an
// arithmetic reference model with its own HI/LO state.
module tb_alu_muldiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         resetN;
  logic         inValid;
  logic         inReady;
  logic [3:0]   aluCtrl;
  logic [W-1:0] input1;
  logic [W-1:0] input2;
  logic [4:0]   shamt;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] result;
  logic         busy;
`ifdef ALU_OVERFLOW_EN
  logic         overflow;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  alu_muldiv_unit #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clock    (clock),
    .resetN   (resetN),
    .inValid  (inValid),
    .inReady  (inReady),
    .aluCtrl  (aluCtrl),
    .input1   (input1),
    .input2   (input2),
    .shamt    (shamt),
    .outValid (outValid),
    .outReady (outReady),
    .result   (result),
    .busy     (busy)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clock = ~clock;

  // Reference for single-cycle ops
  function automatic logic [31:0] ref_single(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh,
                                             input logic [31:0] hi, input logic [31:0] lo);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return b << sh;
      4'd5:    return b >> sh;
      4'd6:    return sb >>> sh;
      4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd8:    return (a < b) ? 32'd1 : 32'd0;
      4'd13:   return hi;
      4'd14:   return lo;
      4'd15:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Reference for multiply/divide: updates model HI/LO
  task automatic ref_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa;
    int     sb;
    sa = a;
    sb = b;
    case (op)
      4'd9: begin
        p = longint'(sa) * longint'(sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      4'd10: begin
        p = longint'({32'd0, a}) * longint'({32'd0, b});
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      4'd11: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'd0;
        end else begin
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end
      end
      default: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
    endcase
  endtask

`ifdef ALU_OVERFLOW_EN
  function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint r;
    int     sa;
    int     sb;
    sa = a;
    sb = b;
    if (op == 4'd0)      r = longint'(sa) + longint'(sb);
    else if (op == 4'd1) r = longint'(sa) - longint'(sb);
    else                 return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction
`endif

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 15));
      2:       return -32'($urandom_range(1, 15));
      default: begin
        case ($urandom_range(0, 3))
          0:       return 32'h0000_0000;
          1:       return 32'h8000_0000;
          2:       return 32'h7FFF_FFFF;
          default: return 32'hFFFF_FFFF;
        endcase
      end
    endcase
  endfunction

  function automatic logic [3:0] rnd_single_op();
    int k;
    k = $urandom_range(0, 11);
    if (k <= 8) return 4'(k);
    return 4'(k + 4);
  endfunction

  // Issue one op and wait for its result. Called at posedge+1.
  // lat = clock edges after the accepting edge until outValid is seen;
  // rdy = cycles inReady was high while waiting.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] res, output int lat,
                       output int rdy);
    int guard;
    aluCtrl = op;
    input1  = a;
    input2  = b;
    shamt   = sh;
    inValid = 1'b1;
    guard   = 0;
    while (!inReady && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    @(posedge clock); #1;
    inValid = 1'b0;
    lat = 0;
    rdy = 0;
    while (!outValid && lat < 200) begin
      if (inReady) rdy++;
      @(posedge clock); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    logic [31:0] res;
    int lat;
    int rdy;
    resetN   = 1'b0;
    inValid  = 1'b1;
    aluCtrl  = 4'd0;
    input1   = 32'd5;
    input2   = 32'd7;
    shamt    = 5'd0;
    outReady = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_vec++;
    if (busy !== 1'b0 || outValid !== 1'b0) begin
      $display("FAIL reset_hold busy=%b outValid=%b exp 0 0", busy, outValid);
      n_err++;
    end
    resetN = 1'b1;
    m_hi = '0;
    m_lo = '0;
    #1;
    n_vec++;
    if (outValid !== 1'b0 || result !== 32'd0 || inReady !== 1'b1) begin
      $display("FAIL reset_release outValid=%b result=%h inReady=%b exp 0 0 1", outValid, result, inReady);
      n_err++;
    end
    do_op(4'd0, 32'd5, 32'd7, 5'd0, res, lat, rdy);
    n_vec++;
    if (res !== 32'd12 || lat !== 0) begin
      $display("FAIL add_5_7 result=%h lat=%0d exp 0000000c lat 0", res, lat);
      n_err++;
    end
    do_op(4'd13, 32'd0, 32'd0, 5'd0, res, lat, rdy);
    n_vec++;
    if (res !== 32'd0) begin
      $display("FAIL reset_hi got %h exp 00000000", res);
      n_err++;
    end
    do_op(4'd14, 32'd0, 32'd0, 5'd0, res, lat, rdy);
    n_vec++;
    if (res !== 32'd0) begin
      $display("FAIL reset_lo got %h exp 00000000", res);
      n_err++;
    end
  endtask

  task automatic test_single();
    logic [3:0]  d_op[3]  = '{4'd6, 4'd7, 4'd8};
    logic [31:0] d_a[3]   = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_b[3]   = '{32'h8000_0000, 32'h1, 32'h1};
    logic [4:0]  d_sh[3]  = '{5'd4, 5'd0, 5'd0};
    logic [31:0] d_exp[3] = '{32'hF800_0000, 32'h1, 32'h0};
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_v;
    logic [3:0]  op;
    logic [4:0]  sh;
    int lat;
    int rdy;
    for (int i = 0; i < 3; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], d_sh[i], res, lat, rdy);
      n_vec++;
      if (res !== d_exp[i]) begin
        $display("FAIL directed_op%0d got %h exp %h", d_op[i], res, d_exp[i]);
        n_err++;
      end
    end
    for (int i = 0; i < 150; i++) begin
      op = rnd_single_op();
      a  = rnd_operand();
      b  = rnd_operand();
      sh = 5'($urandom);
      exp_v = ref_single(op, a, b, sh, m_hi, m_lo);
      do_op(op, a, b, sh, res, lat, rdy);
      n_vec++;
      if (res !== exp_v || lat !== 0) begin
        $display("FAIL single_op%0d a=%h b=%h sh=%0d got %h lat=%0d exp %h lat 0", op, a, b, sh, res, lat, exp_v);
        n_err++;
      end
`ifdef ALU_OVERFLOW_EN
      n_vec++;
      if (overflow !== ref_ovf(op, a, b)) begin
        $display("FAIL ovf_op%0d a=%h b=%h got %b exp %b", op, a, b, overflow, ref_ovf(op, a, b));
        n_err++;
      end
`endif
    end
  endtask

  task automatic test_muldiv();
    logic [3:0]  d_op[4] = '{4'd9, 4'd11, 4'd12, 4'd11};
    logic [31:0] d_a[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd10, 32'h8000_0000};
    logic [31:0] d_b[4]  = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] d_lo[4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] d_hi[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd10, 32'h0};
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    int lat;
    int rdy;
    for (int i = 0; i < 4; i++) begin
      ref_muldiv(d_op[i], d_a[i], d_b[i]);
      do_op(d_op[i], d_a[i], d_b[i], 5'd0, res, lat, rdy);
      n_vec++;
      if (res !== d_lo[i] || lat !== W + 1 || rdy !== 0) begin
        $display("FAIL md_directed%0d lo=%h lat=%0d rdy=%0d exp %h lat %0d rdy 0", i, res, lat, rdy, d_lo[i], W + 1);
        n_err++;
      end
      do_op(4'd13, 32'd0, 32'd0, 5'd0, res, lat, rdy);
      n_vec++;
      if (res !== d_hi[i]) begin
        $display("FAIL md_directed%0d_hi got %h exp %h", i, res, d_hi[i]);
        n_err++;
      end
      do_op(4'd14, 32'd0, 32'd0, 5'd0, res, lat, rdy);
      n_vec++;
      if (res !== d_lo[i]) begin
        $display("FAIL md_directed%0d_lo got %h exp %h", i, res, d_lo[i]);
        n_err++;
      end
    end
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(9, 12));
      a  = rnd_operand();
      b  = rnd_operand();
      ref_muldiv(op, a, b);
      do_op(op, a, b, 5'd0, res, lat, rdy);
      n_vec++;
      if (res !== m_lo || lat !== W + 1 || rdy !== 0) begin
        $display("FAIL md_op%0d a=%h b=%h lo=%h lat=%0d rdy=%0d exp %h lat %0d rdy 0", op, a, b, res, lat, rdy, m_lo, W + 1);
        n_err++;
      end
`ifdef ALU_OVERFLOW_EN
      n_vec++;
      if (overflow !== 1'b0) begin
        $display("FAIL md_ovf got %b exp 0", overflow);
        n_err++;
      end
`endif
      do_op(4'd13, 32'd0, 32'd0, 5'd0, res, lat, rdy);
      n_vec++;
      if (res !== m_hi) begin
        $display("FAIL md_hi_op%0d a=%h b=%h got %h exp %h", op, a, b, res, m_hi);
        n_err++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v;
    logic [3:0]  op;
    for (int i = 0; i < 30; i++) begin
      op      = rnd_single_op();
      aluCtrl = op;
      input1  = rnd_operand();
      input2  = rnd_operand();
      shamt   = 5'($urandom);
      inValid = 1'b1;
      exp_v   = ref_single(op, input1, input2, shamt, m_hi, m_lo);
      n_vec++;
      if (inReady !== 1'b1) begin
        $display("FAIL b2b_ready%0d got %b exp 1", i, inReady);
        n_err++;
      end
      @(posedge clock); #1;
      n_vec++;
      if (outValid !== 1'b1 || result !== exp_v) begin
        $display("FAIL b2b_result%0d op=%0d outValid=%b got %h exp 1 %h", i, op, outValid, result, exp_v);
        n_err++;
      end
    end
    inValid = 1'b0;
    @(posedge clock); #1;
    n_vec++;
    if (outValid !== 1'b0) begin
      $display("FAIL b2b_drain outValid=%b exp 0", outValid);
      n_err++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_and;
    logic [31:0] exp_or;
    int lat;
    int rdy;
    a = $urandom;
    b = $urandom;
    exp_and = a & b;
    outReady = 1'b0;
    do_op(4'd2, a, b, 5'd0, res, lat, rdy);
    n_vec++;
    if (res !== exp_and) begin
      $display("FAIL bp_and got %h exp %h", res, exp_and);
      n_err++;
    end
    aluCtrl = 4'd3;
    input1  = ~a;
    input2  = b;
    exp_or  = ~a | b;
    inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (inReady !== 1'b0) begin
        $display("FAIL bp_ready_low%0d got %b exp 0", i, inReady);
        n_err++;
      end
      @(posedge clock); #1;
      n_vec++;
      if (outValid !== 1'b1 || result !== exp_and) begin
        $display("FAIL bp_hold%0d outValid=%b result=%h exp 1 %h", i, outValid, result, exp_and);
        n_err++;
      end
    end
    outReady = 1'b1;
    #1;
    n_vec++;
    if (inReady !== 1'b1) begin
      $display("FAIL bp_release_ready got %b exp 1", inReady);
      n_err++;
    end
    @(posedge clock); #1;
    inValid = 1'b0;
    n_vec++;
    if (outValid !== 1'b1 || result !== exp_or) begin
      $display("FAIL bp_next outValid=%b result=%h exp 1 %h", outValid, result, exp_or);
      n_err++;
    end
    @(posedge clock); #1;
    n_vec++;
    if (outValid !== 1'b0) begin
      $display("FAIL bp_drain outValid=%b exp 0", outValid);
      n_err++;
    end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] res;
    int lat;
    int rdy;
    int guard;
    ref_muldiv(4'd10, 32'h0012_3457, 32'h0067_8901);
    do_op(4'd10, 32'h0012_3457, 32'h0067_8901, 5'd0, res, lat, rdy);
    n_vec++;
    if (res !== m_lo) begin
      $display("FAIL rst_setup got %h exp %h", res, m_lo);
      n_err++;
    end
    aluCtrl = 4'd11;
    input1  = 32'hFFFF_F000;
    input2  = 32'd3;
    inValid = 1'b1;
    guard   = 0;
    while (!inReady && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    @(posedge clock); #1;
    inValid = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    n_vec++;
    if (busy !== 1'b1) begin
      $display("FAIL rst_busy_before got %b exp 1", busy);
      n_err++;
    end
    #2;
    resetN = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || outValid !== 1'b0 || result !== 32'd0 || inReady !== 1'b1) begin
      $display("FAIL rst_mid_div busy=%b outValid=%b result=%h inReady=%b exp 0 0 0 1", busy, outValid, result, inReady);
      n_err++;
    end
    @(posedge clock); #1;
    resetN = 1'b1;
    m_hi = '0;
    m_lo = '0;
    do_op(4'd13, 32'd0, 32'd0, 5'd0, res, lat, rdy);
    n_vec++;
    if (res !== 32'd0) begin
      $display("FAIL rst_mid_div_hi got %h exp 00000000", res);
      n_err++;
    end
    do_op(4'd14, 32'd0, 32'd0, 5'd0, res, lat, rdy);
    n_vec++;
    if (res !== 32'd0) begin
      $display("FAIL rst_mid_div_lo got %h exp 00000000", res);
      n_err++;
    end
  endtask

`ifdef ALU_OVERFLOW_EN
  task automatic test_overflow();
    logic [3:0]  d_op[4]  = '{4'd0, 4'd1, 4'd0, 4'd1};
    logic [31:0] d_a[4]   = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1, 32'h5};
    logic [31:0] d_b[4]   = '{32'h1, 32'h1, 32'h1, 32'h7};
    logic [31:0] d_res[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFFE};
    logic        d_ovf[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] res;
    int lat;
    int rdy;
    for (int i = 0; i < 4; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], 5'd0, res, lat, rdy);
      n_vec++;
      if (res !== d_res[i] || overflow !== d_ovf[i]) begin
        $display("FAIL ovf_directed%0d result=%h ovf=%b exp %h %b", i, res, overflow, d_res[i], d_ovf[i]);
        n_err++;
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_muldiv();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_div();
`ifdef ALU_OVERFLOW_EN
    test_overflow();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
- Parametrised successor to the single-cycle datapath ALU: adds a valid/ready handshake, a registered result and iterative multiply/divide with HI/LO registers.
- Sits between the register-read stage and writeback.
- The control decoder drives the 4-bit aluCtrl code directly.
- Single-cycle ops complete in 1 cycle; MULT/DIV occupy the unit for WIDTH cycles.

Parameters:
WIDTH, 32, datapath width in bits (>=8, power of 2)
SHAMT_W, 5, shift-amount width; must equal log2(WIDTH)

Ports:
clock  input  1  rising-edge clock
resetN  input  1  asynchronous active-low reset
inValid  input  1  operation request
inReady  output  1  unit can accept a request this cycle
aluCtrl  input  4  op code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SRA, 7 SLT, 8 SLTU, 9 MULT, 10 MULTU, 11 DIV, 12 DIVU, 13 MFHI, 14 MFLO, 15 NOR
input1  input  WIDTH  operand A (rs)
input2  input  WIDTH  operand B (rt)
shamt  input  SHAMT_W  shift amount for SLL/SRL/SRA (shifts input2)
outValid  output  1  result valid
outReady  input  1  consumer accepts result
result  output  WIDTH  registered result
busy  output  1  high while in MUL or DIV state

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, outValid=0, result=0, HI=0, LO=0, busy=0. Reset mid-multiply/divide aborts the operation; HI/LO return to 0.
- inReady = (state==IDLE) && (!outValid || outReady), combinational.
- A request is accepted when inValid && inReady.
- States: IDLE, MUL, DIV, DONE.
- IDLE, accepted op 0-8, 13-15: result is computed and registered in the same edge; outValid=1 next cycle. This gives 1-cycle latency, with back-to-back issue allowed when outReady=1.
- ADD/SUB: wrap modulo 2^WIDTH.
- SLT: signed compare; SLTU: unsigned compare; result is 1 or 0, zero-extended.
- SRA: arithmetic shift of input2. SLL/SRL: logical shifts of input2.
- MFHI/MFLO return the current HI/LO.
- Accepted op 9-12: operands are latched and state goes to MUL or DIV. busy=1, counter=0.
  - Signed ops (MULT, DIV) operate on absolute values; the sign is fixed at completion.
- MUL: shift-add, one bit per cycle, for WIDTH cycles, then DONE.
  - HI:LO = 2*WIDTH-bit product.
  - Signed: product negated if the operand signs differ.
- DIV: restoring division, one quotient bit per cycle, for WIDTH cycles, then DONE.
  - LO = quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - Divisor = 0: LO = all ones, HI = input1. No exception; same latency.
  - Signed overflow case (most-negative / -1): LO = most-negative, HI = 0.
- DONE: HI/LO are written, result = LO, outValid=1, state=IDLE, busy=0.
  - Latency from acceptance to outValid is WIDTH+1 cycles.
- outValid and result hold stable until outReady is high on a clock edge; then outValid clears unless a new op completes that same edge.
- inValid while busy: ignored (inReady=0). Caller must hold the request.
- MFHI issued immediately after a MULT acceptance is blocked until DONE, so it always observes the updated HI.
- aluCtrl values are all defined; there is no illegal code.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit), registered with result and valid with outValid.
  - Set for signed ADD when the operands have equal sign and the result sign differs.
  - Set for SUB when the operand signs differ and the result sign differs from input1.
  - 0 for all other ops.
  - Result is still written (wrapped value); trap handling is the pipeline's job.
  - Reset value 0.
- Undefined: port absent and no overflow logic.

Test Plan:
- Reset with inValid=1, then release -> outValid=0, result=0, inReady=1; first ADD 5+7 -> result=12 one cycle after acceptance.
- SRA input2=0x80000000, shamt=4 -> 0xF8000000. SLT 0xFFFFFFFF vs 1 -> 1. SLTU same operands -> 0.
- MULT 0xFFFFFFFD (-3) x 7, then MFHI/MFLO -> LO=0xFFFFFFEB, HI=0xFFFFFFFF. outValid exactly 33 cycles after acceptance; inReady=0 throughout.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 10/0 -> LO=0xFFFFFFFF, HI=10.
- Hold outReady=0 for 5 cycles after an AND result -> result/outValid stable, inReady=0, new inValid not accepted; outReady=1 -> next op accepted that edge.
- With ALU_OVERFLOW_EN: ADD 0x7FFFFFFF+1 -> result=0x80000000, overflow=1. SUB 0x80000000-1 -> overflow=1. Assert resetN low mid-DIV -> busy=0, HI=LO=0 immediately.
